// File: rtl/golden_nonce_queue_pkg.sv
// Shared widths, limits and payload types for the golden nonce capture path.
package golden_nonce_queue_pkg;

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned OVF_W   = 8;
    localparam logic [OVF_W-1:0] OVF_MAX = 8'hFF;

    typedef logic [NONCE_W-1:0] nonce_t;

    // Progress snapshot: running nonce and its matching hash word, captured together.
    typedef struct packed {
        nonce_t nonce;
        nonce_t hash;
    } snap_t;

    // Nonce correction applied before queuing; plain modulo-2^32 subtraction.
    function automatic nonce_t adj_nonce(input nonce_t gn, input nonce_t adj);
        return gn - adj;
    endfunction

endpackage

// File: rtl/gn_fifo_fwft.sv
// First-word-fall-through queue with registered head, explicit count and full flag.
module gn_fifo_fwft #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full
);

    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nx;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_next;
    logic [W-1:0]  dout_next;

    // Accept/advance decisions and the value the head register takes after this edge.
    always_comb begin
        rd_ptr_nx  = rd_ptr + AW'(1);
        do_pop     = pop && (count != '0);
        do_push    = push && (!full || do_pop);
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
        dout_next = dout;
        if (count_next == '0) begin
            dout_next = '0;
        end else if (do_push && ((count == '0) || ((count == CW'(1)) && do_pop))) begin
            // Queue was empty, or its only entry leaves: the incoming word becomes head.
            dout_next = din;
        end else if (do_pop) begin
            dout_next = mem[rd_ptr_nx];
        end
    end

    // Storage, pointers, count and head register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nx;
            end
            count <= count_next;
            dout  <= dout_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/golden_nonce_queue.sv
// Captures each new golden nonce from the miner core into a FWFT queue and
// keeps an atomic nonce2/hash2 snapshot for progress reporting.
module golden_nonce_queue
    import golden_nonce_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = 3,
    parameter logic [31:0] GN_ADJ = 32'd0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   golden_nonce,
    input  logic [31:0]   nonce2,
    input  logic [31:0]   hash2,
    input  logic          rd_req,
    input  logic          snap_req,
    output logic [31:0]   out_nonce,
    output logic          out_valid,
    output logic [AW:0]   count,
    output logic [7:0]    overflow_cnt,
    output logic [31:0]   snap_nonce,
    output logic [31:0]   snap_hash
);

    localparam int unsigned CW = AW + 1;

    nonce_t gn_r;
    nonce_t gn_last;
    snap_t  snap_q;
    logic   hit;
    logic   pop_ok;
    logic   fifo_full;
    logic   fifo_push;
    logic   drop;

    // Change detector; a full queue accepts a hit only if a pop frees a slot this cycle.
    always_comb begin
        hit       = (gn_r != gn_last);
        pop_ok    = rd_req && (count != '0);
        fifo_push = hit && (!fifo_full || pop_ok);
        drop      = hit && fifo_full && !pop_ok;
    end

    gn_fifo_fwft #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (NONCE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (adj_nonce(gn_r, GN_ADJ)),
        .pop   (rd_req),
        .dout  (out_nonce),
        .count (count),
        .full  (fifo_full)
    );

    // Input register, last-hit tracker, valid flag, overflow saturator and snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            gn_r         <= '0;
            gn_last      <= '0;
            out_valid    <= 1'b0;
            overflow_cnt <= '0;
            snap_q       <= '0;
        end else begin
            gn_r <= golden_nonce;
            if (hit) begin
                gn_last <= gn_r;
            end
            out_valid <= fifo_push || (count > CW'(1)) || ((count == CW'(1)) && !pop_ok);
            if (drop && (overflow_cnt != OVF_MAX)) begin
                overflow_cnt <= overflow_cnt + OVF_W'(1);
            end
            if (snap_req) begin
                snap_q.nonce <= nonce2;
                snap_q.hash  <= hash2;
            end
        end
    end

    assign snap_nonce = snap_q.nonce;
    assign snap_hash  = snap_q.hash;

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Directed bench for golden_nonce_queue: a per-cycle vector table plus
// hand-written sequences for overflow, full push+pop, reset and saturation.
module tb_golden_nonce_queue;

    logic        clk;
    logic        reset;
    logic [31:0] golden_nonce;
    logic [31:0] nonce2;
    logic [31:0] hash2;
    logic        rd_req;
    logic        snap_req;

    logic [31:0] out_nonce,  a_out_nonce;
    logic        out_valid,  a_out_valid;
    logic [3:0]  count,      a_count;
    logic [7:0]  overflow_cnt, a_overflow_cnt;
    logic [31:0] snap_nonce, a_snap_nonce;
    logic [31:0] snap_hash,  a_snap_hash;

    int n_cmp;
    int n_bad;

    golden_nonce_queue #(.DEPTH(8), .AW(3), .GN_ADJ(32'd0)) dut (
        .clk(clk), .reset(reset), .golden_nonce(golden_nonce), .nonce2(nonce2),
        .hash2(hash2), .rd_req(rd_req), .snap_req(snap_req),
        .out_nonce(out_nonce), .out_valid(out_valid), .count(count),
        .overflow_cnt(overflow_cnt), .snap_nonce(snap_nonce), .snap_hash(snap_hash)
    );

    golden_nonce_queue #(.DEPTH(8), .AW(3), .GN_ADJ(32'd2)) dut_adj (
        .clk(clk), .reset(reset), .golden_nonce(golden_nonce), .nonce2(nonce2),
        .hash2(hash2), .rd_req(rd_req), .snap_req(snap_req),
        .out_nonce(a_out_nonce), .out_valid(a_out_valid), .count(a_count),
        .overflow_cnt(a_overflow_cnt), .snap_nonce(a_snap_nonce), .snap_hash(a_snap_hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] gn;
        logic        rd;
        logic        snap;
        logic [31:0] n2;
        logic [31:0] h2;
        logic        ev;
        logic [3:0]  ec;
        logic [31:0] en;
        logic [31:0] ena;
        logic [31:0] esn;
        logic [31:0] esh;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(input logic rst, input logic [31:0] gn, input logic rd,
                                input logic snap, input logic [31:0] n2, input logic [31:0] h2,
                                input logic ev, input logic [3:0] ec, input logic [31:0] en,
                                input logic [31:0] ena, input logic [31:0] esn,
                                input logic [31:0] esh);
        vec_t v;
        v.rst = rst; v.gn = gn; v.rd = rd; v.snap = snap; v.n2 = n2; v.h2 = h2;
        v.ev = ev; v.ec = ec; v.en = en; v.ena = ena; v.esn = esn; v.esh = esh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, take the edge, settle before sampling.
    task automatic step(input logic rst, input logic [31:0] gn, input logic rd,
                        input logic snap, input logic [31:0] n2, input logic [31:0] h2);
        reset = rst; golden_nonce = gn; rd_req = rd; snap_req = snap;
        nonce2 = n2; hash2 = h2;
        @(posedge clk);
        #1;
    endtask

    task automatic gn_step(input logic [31:0] gn, input logic rd);
        step(1'b0, gn, rd, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1; golden_nonce = '0; rd_req = 1'b0; snap_req = 1'b0;
        nonce2 = '0; hash2 = '0;

        // Idle with zero input: the reset value of the miner never counts as a hit.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            gn_step(32'd0, 1'b0);
            chk($sformatf("idle_valid[%0d]", i), 32'(out_valid), 32'd0);
            chk($sformatf("idle_count[%0d]", i), 32'(count), 32'd0);
        end

        // Per-cycle vectors: latency, pop, wrap-around adjust, snapshot, push+pop.
        vt[0]  = mk(1, 32'h0,         0, 0, 32'd0, 32'd0,        0, 0, 32'h0,         32'h0,         32'd0, 32'd0);
        vt[1]  = mk(0, 32'h1234_5678, 0, 0, 32'd0, 32'd0,        0, 0, 32'h0,         32'h0,         32'd0, 32'd0);
        vt[2]  = mk(0, 32'h1234_5678, 0, 0, 32'd0, 32'd0,        1, 1, 32'h1234_5678, 32'h1234_5676, 32'd0, 32'd0);
        vt[3]  = mk(0, 32'h1234_5678, 0, 0, 32'd0, 32'd0,        1, 1, 32'h1234_5678, 32'h1234_5676, 32'd0, 32'd0);
        vt[4]  = mk(0, 32'h1234_5678, 1, 0, 32'd0, 32'd0,        0, 0, 32'h0,         32'h0,         32'd0, 32'd0);
        vt[5]  = mk(0, 32'h0000_0001, 0, 0, 32'd0, 32'd0,        0, 0, 32'h0,         32'h0,         32'd0, 32'd0);
        vt[6]  = mk(0, 32'h0000_0001, 0, 0, 32'd0, 32'd0,        1, 1, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0, 32'd0);
        vt[7]  = mk(0, 32'h0000_0001, 1, 0, 32'd0, 32'd0,        0, 0, 32'h0,         32'h0,         32'd0, 32'd0);
        vt[8]  = mk(0, 32'h0000_0001, 0, 1, 32'd5, 32'hA41F32E7, 0, 0, 32'h0,         32'h0,         32'd5, 32'hA41F32E7);
        vt[9]  = mk(0, 32'h0000_0001, 0, 0, 32'd9, 32'd0,        0, 0, 32'h0,         32'h0,         32'd5, 32'hA41F32E7);
        vt[10] = mk(0, 32'h0000_AAAA, 0, 0, 32'd0, 32'd0,        0, 0, 32'h0,         32'h0,         32'd5, 32'hA41F32E7);
        vt[11] = mk(0, 32'h0000_BBBB, 0, 0, 32'd0, 32'd0,        1, 1, 32'h0000_AAAA, 32'h0000_AAA8, 32'd5, 32'hA41F32E7);
        vt[12] = mk(0, 32'h0000_BBBB, 1, 0, 32'd0, 32'd0,        1, 1, 32'h0000_BBBB, 32'h0000_BBB9, 32'd5, 32'hA41F32E7);
        vt[13] = mk(0, 32'h0000_BBBB, 1, 0, 32'd0, 32'd0,        0, 0, 32'h0,         32'h0,         32'd5, 32'hA41F32E7);
        vt[14] = mk(0, 32'h0000_CCCC, 0, 0, 32'd0, 32'd0,        0, 0, 32'h0,         32'h0,         32'd5, 32'hA41F32E7);
        vt[15] = mk(0, 32'h0000_CCCC, 1, 0, 32'd0, 32'd0,        1, 1, 32'h0000_CCCC, 32'h0000_CCCA, 32'd5, 32'hA41F32E7);
        vt[16] = mk(0, 32'h0000_CCCC, 1, 0, 32'd0, 32'd0,        0, 0, 32'h0,         32'h0,         32'd5, 32'hA41F32E7);

        for (int i = 0; i < 17; i++) begin
            step(vt[i].rst, vt[i].gn, vt[i].rd, vt[i].snap, vt[i].n2, vt[i].h2);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].ec));
            chk($sformatf("vec%0d_nonce", i), out_nonce, vt[i].en);
            chk($sformatf("vec%0d_adj_nonce", i), a_out_nonce, vt[i].ena);
            chk($sformatf("vec%0d_snap_nonce", i), snap_nonce, vt[i].esn);
            chk($sformatf("vec%0d_snap_hash", i), snap_hash, vt[i].esh);
        end

        // Ten distinct hits into eight slots, then drain in order.
        do_reset();
        for (int k = 1; k <= 10; k++) gn_step(32'h100 + 32'(k), 1'b0);
        gn_step(32'h10A, 1'b0);
        gn_step(32'h10A, 1'b0);
        chk("ovf10_count", 32'(count), 32'd8);
        chk("ovf10_ovf", 32'(overflow_cnt), 32'd2);
        chk("ovf10_valid", 32'(out_valid), 32'd1);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("ovf10_pop%0d", j), out_nonce, 32'h101 + 32'(j));
            gn_step(32'h10A, 1'b1);
        end
        chk("ovf10_drain_valid", 32'(out_valid), 32'd0);
        chk("ovf10_drain_nonce", out_nonce, 32'd0);
        chk("ovf10_drain_count", 32'(count), 32'd0);

        // Full queue with a new hit and a pop on the same edge.
        do_reset();
        for (int k = 1; k <= 8; k++) gn_step(32'h200 + 32'(k), 1'b0);
        gn_step(32'h208, 1'b0);
        chk("full_count", 32'(count), 32'd8);
        gn_step(32'h300, 1'b0);
        gn_step(32'h300, 1'b1);
        chk("fullpp_count", 32'(count), 32'd8);
        chk("fullpp_ovf", 32'(overflow_cnt), 32'd0);
        chk("fullpp_head", out_nonce, 32'h202);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("fullpp_pop%0d", j), out_nonce, (j < 7) ? 32'h202 + 32'(j) : 32'h300);
            gn_step(32'h300, 1'b1);
        end
        chk("fullpp_drain_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of operation with entries queued and a snapshot held.
        do_reset();
        gn_step(32'h11, 1'b0);
        gn_step(32'h22, 1'b0);
        gn_step(32'h33, 1'b0);
        gn_step(32'h33, 1'b0);
        step(1'b0, 32'h33, 1'b0, 1'b1, 32'd7, 32'd8);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_head", out_nonce, 32'h11);
        chk("pre_rst_snap", snap_nonce, 32'd7);
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_nonce", out_nonce, 32'd0);
        chk("rst_ovf", 32'(overflow_cnt), 32'd0);
        chk("rst_snap_nonce", snap_nonce, 32'd0);
        chk("rst_snap_hash", snap_hash, 32'd0);
        chk("rst_adj_count", 32'(a_count), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'd5, 32'hA41F32E7);
        chk("snap_nonce", snap_nonce, 32'd5);
        chk("snap_hash", snap_hash, 32'hA41F32E7);
        chk("snap_no_hit", 32'(count), 32'd0);

        // Overflow counter climbs and then saturates.
        do_reset();
        for (int k = 1; k <= 270; k++) begin
            gn_step(32'(k), 1'b0);
            if (k == 100) chk("sat_mid_ovf", 32'(overflow_cnt), 32'd91);
        end
        gn_step(32'd270, 1'b0);
        chk("sat_ovf", 32'(overflow_cnt), 32'd255);
        chk("sat_count", 32'(count), 32'd8);
        chk("sat_head", out_nonce, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
